// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-sign helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_q
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // Remainder shifted left with the next dividend bit, minus the divisor.
    w_diff = i_acc[2*XLEN-1:XLEN-1] - {1'b0, i_opnd};
    o_q    = 1'b0;
    o_acc  = {w_sum, i_acc[XLEN-1:1]};
    if (i_div) begin
      o_q   = ~w_diff[XLEN];
      o_acc = {(o_q ? w_diff[XLEN-1:0] : i_acc[2*XLEN-2:XLEN-1]), i_acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] Reg1,
  input  logic [XLEN-1:0] Reg2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  state_e            r_state;
  logic [2:0]        r_op;
  logic              r_neg_a, r_neg_b;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy, r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_sa, w_sb;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic              w_div0, w_ovf, w_imm, w_fast;
  logic [XLEN-1:0]   w_imm_res;
  logic [2*XLEN-1:0] w_step_acc, w_acc_fin, w_prod;
  logic              w_step_q;
  logic [XLEN-1:0]   w_quo, w_rem, w_res_fin;

  assign w_sa    = is_signed_a(op) & Reg1[XLEN-1];
  assign w_sb    = is_signed_b(op) & Reg2[XLEN-1];
  assign w_abs_a = w_sa ? -Reg1 : Reg1;
  assign w_abs_b = w_sb ? -Reg2 : Reg2;
  assign w_div0  = is_div(op) && (Reg2 == '0);
  assign w_ovf   = ((op == MD_DIV) || (op == MD_REM)) &&
                   (Reg1 == {1'b1, {(XLEN-1){1'b0}}}) && (Reg2 == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fprod;
  assign w_fprod = {{XLEN{w_sa}}, Reg1} * {{XLEN{w_sb}}, Reg2};
  assign w_fast  = ~is_div(op);
`else
  assign w_fast  = 1'b0;
`endif

  assign w_imm = w_div0 | w_ovf | w_fast;

  // Results resolved in IDLE without iterating; op[1] selects remainder vs quotient.
  always_comb begin
    w_imm_res = '0;
    if (w_div0) begin
      w_imm_res = op[1] ? Reg1 : '1;
    end else if (w_ovf) begin
      w_imm_res = op[1] ? '0 : Reg1;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (w_fast) begin
      w_imm_res = (op == MD_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  muldiv_iter_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_div  (is_div(r_op)),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_q    (w_step_q)
  );

  assign w_acc_fin = {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_step_q};
  assign w_prod    = (r_neg_a ^ r_neg_b) ? -w_acc_fin : w_acc_fin;
  assign w_quo     = (r_neg_a ^ r_neg_b) ? -w_acc_fin[XLEN-1:0] : w_acc_fin[XLEN-1:0];
  assign w_rem     = r_neg_a ? -w_acc_fin[2*XLEN-1:XLEN] : w_acc_fin[2*XLEN-1:XLEN];

  always_comb begin
    w_res_fin = '0;
    case (r_op)
      MD_MUL:                       w_res_fin = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_res_fin = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_res_fin = w_quo;
      default:                      w_res_fin = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !flush) begin
            r_op    <= op;
            r_neg_a <= w_sa;
            r_neg_b <= w_sb;
            r_cnt   <= '0;
            if (w_imm) begin
              r_result <= w_imm_res;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_opnd  <= is_div(op) ? w_abs_b : w_abs_a;
              r_acc   <= {{XLEN{1'b0}}, (is_div(op) ? w_abs_a : w_abs_b)};
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_acc_fin;
            if (r_cnt == CNT_W'(XLEN-1)) begin
              r_result <= w_res_fin;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A flush during the DONE cycle suppresses the pulse.
  assign done   = r_done & ~flush;
  assign busy   = r_busy;
  assign stall  = (start && (r_state == ST_IDLE)) || r_busy;
  assign Result = r_result;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations, which the single-cycle ALU does not provide.
- Sits beside the ALU in the execute stage and accepts one operation at a time via a start/busy/done handshake.
- Runs an iterative shift-add multiply or restoring divide over XLEN cycles.
- Drives `stall` so the pipeline holds the instruction until the result is ready.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; one clock, no other clock domain.
- start  input  1  request; sampled only in IDLE.
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Reg1  input  XLEN  rs1 operand (multiplicand/dividend); captured on accepted start.
- Reg2  input  XLEN  rs2 operand (multiplier/divisor); captured on accepted start.
- flush  input  1  abort current operation (pipeline flush).
- busy  output  1  high in CALC.
- stall  output  1  start & IDLE, or busy; holds the execute stage.
- done  output  1  one-cycle pulse, Result valid.
- Result  output  XLEN  final value; held until next accepted start.

Behaviour:
- States: IDLE, CALC, DONE; encoding from the package.
- Reset: state=IDLE, busy=0, done=0, Result=0, counter=0, internal accumulators=0.
- Reset mid-operation aborts immediately; no done is produced.
- IDLE: start=1 and flush=0 captures op, Reg1, Reg2 and the operand signs.
  - Special case (see below): go to DONE.
  - Otherwise: go to CALC with count=0.
- CALC:
  - One iteration per cycle on absolute-value operands.
  - Multiply: 2*XLEN-bit product register, shift-add, LSB of multiplier first.
  - Divide: restoring, XLEN-bit remainder/quotient.
  - After iteration XLEN-1, apply sign fixup, load Result, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - A start in DONE is ignored; the requester re-presents it in IDLE.
- Latency: start accepted on edge E0 → done high in cycle XLEN+1 (33 at default).
  - Special cases: done high in cycle 1.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: Reg1 signed, Reg2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Product result: negated if operand signs differ.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU, MULHU return product[2*XLEN-1:XLEN].
- Quotient result: negated if operand signs differ.
- Remainder result: takes the sign of the dividend.
- Special cases, resolved without iterating:
  - Divide by zero: quotient = all ones; remainder = Reg1.
  - Signed overflow (Reg1=0x80000000, Reg2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- flush:
  - In CALC or DONE: go to IDLE next edge; done suppressed; Result unchanged.
  - In IDLE: flush and start together → flush wins, start dropped.
- start while CALC: ignored; captured operands do not change.
- Counter stops at XLEN-1; no wrap.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - All multiply ops compute in one cycle using a combinational 2*XLEN-bit signed/unsigned product.
  - Path is IDLE → DONE; done in cycle 1.
  - Divide ops remain iterative.
- Undefined: multiplies use the iterative path (XLEN+1 latency).
- Handshake and Result semantics are identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 op constants: MD_MUL .. MD_REMU.
  - State encoding: ST_IDLE, ST_CALC, ST_DONE.
  - XLEN default.
  - Helpers: is_div(op), is_signed_a(op), is_signed_b(op).
- One sub-module, muldiv_iter_step: combinational single-iteration datapath for both modes.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator and next quotient bit.
- FSM, counter and sign fixup stay in muldiv_seq.

Test Plan:
- MUL Reg1=7, Reg2=0xFFFFFFFD → Result=0xFFFFFFEB; done exactly in cycle 33, single pulse; busy high in cycles 1–32; stall high from start.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF and REM 0x1234 / 0 → 0x1234, both with done in cycle 1; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- Start DIVU, change Reg1/Reg2 and pulse start at cycle 5 → Result uses the original operands; flush at cycle 10 of a new op → IDLE next edge, no done, Result retains previous value.
- rst asserted asynchronously mid-CALC → busy, done, Result=0 immediately; a new start afterwards completes normally. Repeat MUL timing with MULDIV_FAST_MUL_EN → done in cycle 1.
